// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge.
// Each AHB transfer becomes one APB setup/access pair.
module ahb_to_apb_bridge #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  output logic [2:0]            PPROT,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [31:0]           PRDATA
);

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [3:0]            strb;
    logic [2:0]            prot;
  } apb_req_t;

  state_t      state;
  state_t      state_nxt;
  apb_req_t    req;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  strb_nxt;
  logic        accept;
  logic        done;
  logic        unused;

  assign unused = ^{HTRANS[0], HPROT[3:2]};

  assign accept = HSEL & HTRANS[1] & HREADY &
                  ((state == IDLE) | (state == ERR2));

  assign done = (state == ACCESS) & PREADY;

  always_comb begin
    strb_nxt = 4'b1111;
    unique case (1'b1)
      (HSIZE == 3'd0): strb_nxt = 4'b0001 << HADDR[1:0];
      (HSIZE == 3'd1): strb_nxt = HADDR[1] ? 4'b1100 : 4'b0011;
      default:         strb_nxt = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, ERR2: begin
        if (accept) begin
          state_nxt = HWRITE ? WDATA : SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      WDATA:  state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_nxt = PSLVERR ? ERR1 : IDLE;
        end
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b0;
    HRESP     = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    unique case (state)
      IDLE:   HREADYOUT = 1'b1;
      WDATA:  HREADYOUT = 1'b0;
      SETUP:  PSEL      = 1'b1;
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      ERR1:   HRESP = 1'b1;
      ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: HREADYOUT = 1'b1;
    endcase
  end

  // Request fields only load on accept, so they stay frozen through ACCESS.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      req <= '0;
    end else if (accept) begin
      req.addr  <= {HADDR[ADDR_WIDTH-1:2], 2'b00};
      req.write <= HWRITE;
      req.strb  <= HWRITE ? strb_nxt : 4'b0000;
      req.prot  <= {~HPROT[0], HPROT[1], 1'b0};
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wdata_q <= '0;
    end else if (state == WDATA) begin
      wdata_q <= HWDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rdata_q <= '0;
    end else if (done & ~PSLVERR & ~req.write) begin
      rdata_q <= PRDATA;
    end
  end

  assign HRDATA = rdata_q;
  assign PADDR  = req.addr;
  assign PWRITE = req.write;
  assign PSTRB  = req.strb;
  assign PPROT  = req.prot;
  assign PWDATA = wdata_q;

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Directed bench for ahb_to_apb_bridge.
// Vector table plus hand-written multi-cycle sequences.
module tb_ahb_to_apb_bridge;

  localparam int AW = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [3:0]    HPROT;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [3:0]    PSTRB;
  logic [2:0]    PPROT;
  logic          PREADY;
  logic          PSLVERR;
  logic [31:0]   PRDATA;

  int checks = 0;
  int errors = 0;

  ahb_to_apb_bridge #(.ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT),
    .HREADY(HREADY), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        err;
    int          exp_low;
    logic        exp_resp;
    logic [15:0] exp_paddr;
    logic [3:0]  exp_strb;
    logic [2:0]  exp_prot;
    logic [31:0] exp_hrdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic drive_addr(input logic [15:0] a, input logic w,
                            input logic [2:0] s);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = s;
    HPROT  = 4'b0011;
    HREADY = 1'b1;
  endtask

  task automatic drive_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          low;
    int          psel_n;
    int          pen_n;
    logic        stable;
    logic        fin;
    logic [15:0] sa;
    logic [3:0]  ss;
    logic        sw;
    logic [31:0] sd;
    logic [2:0]  sp;
    string       tag;
    low    = 0;
    psel_n = 0;
    pen_n  = 0;
    stable = 1'b1;
    fin    = 1'b0;
    sa = '0; ss = '0; sw = 1'b0; sd = '0; sp = '0;
    tag = $sformatf("vec%0d", idx);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = v.addr; HWRITE = v.wr;
    HSIZE = v.size; HPROT = v.prot; HREADY = 1'b1;
    @(posedge HCLK); #1;
    drive_idle();
    HWDATA = v.wdata;
    PRDATA = v.prdata;
    for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
      @(negedge HCLK);
      if (HREADYOUT) begin
        fin = 1'b1;
      end else begin
        low++;
        if (PSEL && !PENABLE) begin
          psel_n++;
          sa = PADDR; ss = PSTRB; sw = PWRITE; sd = PWDATA; sp = PPROT;
        end
        if (PSEL && PENABLE) begin
          psel_n++;
          pen_n++;
          if (PADDR !== sa || PSTRB !== ss || PWRITE !== sw ||
              PWDATA !== sd || PPROT !== sp) stable = 1'b0;
          PREADY  = (pen_n > v.waits);
          PSLVERR = v.err & PREADY;
        end
        @(posedge HCLK); #1;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
    end
    check({tag, " done"}, 32'(fin), 32'd1);
    check({tag, " low_cycles"}, 32'(low), 32'(v.exp_low));
    check({tag, " hresp"}, 32'(HRESP), 32'(v.exp_resp));
    check({tag, " hrdata"}, HRDATA, v.exp_hrdata);
    check({tag, " paddr"}, 32'(sa), 32'(v.exp_paddr));
    check({tag, " pstrb"}, 32'(ss), 32'(v.exp_strb));
    check({tag, " pwrite"}, 32'(sw), 32'(v.wr));
    check({tag, " pprot"}, 32'(sp), 32'(v.exp_prot));
    check({tag, " psel_cycles"}, 32'(psel_n), 32'(v.waits + 2));
    check({tag, " penable_cycles"}, 32'(pen_n), 32'(v.waits + 1));
    check({tag, " stable"}, 32'(stable), 32'd1);
    if (v.wr) check({tag, " pwdata"}, sd, v.wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // addr wr size prot wdata prdata waits err | low resp paddr strb prot hrdata
    vecs[0] = '{16'h0010, 1'b0, 3'd2, 4'h3, 32'h0, 32'hA5A5_1234, 0, 1'b0,
                2, 1'b0, 16'h0010, 4'b0000, 3'b010, 32'hA5A5_1234};
    vecs[1] = '{16'h0004, 1'b1, 3'd2, 4'h0, 32'hDEAD_BEEF, 32'h0, 0, 1'b0,
                3, 1'b0, 16'h0004, 4'b1111, 3'b100, 32'hA5A5_1234};
    vecs[2] = '{16'h0007, 1'b1, 3'd0, 4'h1, 32'h1122_3344, 32'h0, 0, 1'b0,
                3, 1'b0, 16'h0004, 4'b1000, 3'b000, 32'hA5A5_1234};
    vecs[3] = '{16'h0002, 1'b1, 3'd1, 4'h2, 32'h5566_7788, 32'h0, 0, 1'b0,
                3, 1'b0, 16'h0000, 4'b1100, 3'b110, 32'hA5A5_1234};
    vecs[4] = '{16'h0001, 1'b1, 3'd0, 4'h3, 32'h0000_00AB, 32'h0, 0, 1'b0,
                3, 1'b0, 16'h0000, 4'b0010, 3'b010, 32'hA5A5_1234};
    vecs[5] = '{16'h0006, 1'b1, 3'd1, 4'h0, 32'h0000_CDEF, 32'h0, 2, 1'b0,
                5, 1'b0, 16'h0004, 4'b1100, 3'b100, 32'hA5A5_1234};
    vecs[6] = '{16'h0020, 1'b0, 3'd2, 4'h3, 32'h0, 32'h0BAD_F00D, 3, 1'b0,
                5, 1'b0, 16'h0020, 4'b0000, 3'b010, 32'h0BAD_F00D};
    vecs[7] = '{16'h0030, 1'b1, 3'd2, 4'h0, 32'h1357_2468, 32'h0, 0, 1'b1,
                4, 1'b1, 16'h0030, 4'b1111, 3'b100, 32'h0BAD_F00D};
    vecs[8] = '{16'h0040, 1'b0, 3'd2, 4'h3, 32'h0, 32'h1234_5678, 1, 1'b1,
                4, 1'b1, 16'h0040, 4'b0000, 3'b010, 32'h0BAD_F00D};
    vecs[9] = '{16'h0013, 1'b0, 3'd0, 4'h3, 32'h0, 32'hFFFF_0000, 0, 1'b0,
                2, 1'b0, 16'h0010, 4'b0000, 3'b010, 32'hFFFF_0000};

    HRESETn = 1'b0;
    HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd0; HPROT = 4'h0; HREADY = 1'b1; HWDATA = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst hready_resp", 32'({HREADYOUT, HRESP}), 32'b10);
    check("rst psel_pen", 32'({PSEL, PENABLE, PWRITE}), 32'b000);
    check("rst hrdata", HRDATA, 32'h0);
    check("rst paddr_strb_prot", 32'({PADDR, PSTRB, PPROT}), 32'h0);
    check("rst pwdata", PWDATA, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Transfers that must not be accepted
    for (int k = 0; k < 4; k++) begin
      @(posedge HCLK); #1;
      drive_addr(16'h0010, 1'b0, 3'd2);
      if (k == 0) HTRANS = 2'b00;
      if (k == 1) HTRANS = 2'b01;
      if (k == 2) HSEL = 1'b0;
      if (k == 3) HREADY = 1'b0;
      @(posedge HCLK); #1;
      drive_idle();
      HREADY = 1'b1;
      @(negedge HCLK);
      check($sformatf("noaccept%0d", k), 32'({PSEL, HREADYOUT, HRESP}),
            32'b010);
    end

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Error response, then a read accepted during ERR2
    @(posedge HCLK); #1;
    drive_addr(16'h0050, 1'b1, 3'd2);
    @(posedge HCLK); #1;
    drive_idle();
    HWDATA = 32'h0F0F_0F0F;
    @(posedge HCLK);
    @(posedge HCLK);
    @(negedge HCLK);
    check("err access", 32'({PSEL, PENABLE}), 32'b11);
    PREADY = 1'b1; PSLVERR = 1'b1;
    @(posedge HCLK); #1;
    PREADY = 1'b0; PSLVERR = 1'b0;
    @(negedge HCLK);
    check("err1 ready_resp_psel", 32'({HREADYOUT, HRESP, PSEL}), 32'b010);
    @(posedge HCLK); #1;
    drive_addr(16'h0060, 1'b0, 3'd2);
    @(negedge HCLK);
    check("err2 ready_resp", 32'({HREADYOUT, HRESP}), 32'b11);
    @(posedge HCLK); #1;
    drive_idle();
    PRDATA = 32'hCAFE_0001;
    @(negedge HCLK);
    check("err2 read setup", 32'({PSEL, PENABLE, HRESP, HREADYOUT}),
          32'b1000);
    check("err2 read paddr", 32'(PADDR), 32'h0060);
    @(posedge HCLK);
    @(negedge HCLK);
    PREADY = 1'b1;
    @(posedge HCLK); #1;
    PREADY = 1'b0;
    @(negedge HCLK);
    check("err2 read done", 32'({HREADYOUT, HRESP}), 32'b10);
    check("err2 read hrdata", HRDATA, 32'hCAFE_0001);

    // Back-to-back read then write, no idle between
    @(posedge HCLK); #1;
    drive_addr(16'h0000, 1'b0, 3'd2);
    @(posedge HCLK); #1;
    drive_idle();
    PRDATA = 32'h5555_AAAA;
    @(posedge HCLK);
    @(negedge HCLK);
    PREADY = 1'b1;
    @(posedge HCLK); #1;
    PREADY = 1'b0;
    drive_addr(16'h0008, 1'b1, 3'd2);
    @(negedge HCLK);
    check("b2b rd done", 32'({HREADYOUT, PSEL, PENABLE}), 32'b100);
    check("b2b rd hrdata", HRDATA, 32'h5555_AAAA);
    @(posedge HCLK); #1;
    drive_idle();
    HWDATA = 32'h0102_0304;
    @(negedge HCLK);
    check("b2b wdata", 32'({PSEL, HREADYOUT}), 32'b00);
    @(posedge HCLK);
    @(negedge HCLK);
    check("b2b setup", 32'({PSEL, PENABLE, PWRITE, PSTRB}), 32'b1011111);
    check("b2b paddr", 32'(PADDR), 32'h0008);
    check("b2b pwdata", PWDATA, 32'h0102_0304);
    @(posedge HCLK);
    @(negedge HCLK);
    PREADY = 1'b1;
    @(posedge HCLK); #1;
    PREADY = 1'b0;
    @(negedge HCLK);
    check("b2b wr done", 32'({HREADYOUT, HRESP, PSEL}), 32'b100);

    // Asynchronous reset while in ACCESS
    @(posedge HCLK); #1;
    drive_addr(16'h0070, 1'b0, 3'd2);
    @(posedge HCLK); #1;
    drive_idle();
    @(posedge HCLK);
    @(negedge HCLK);
    check("rstmid access", 32'({PSEL, PENABLE, HREADYOUT}), 32'b110);
    #1 HRESETn = 1'b0;
    #1;
    check("rstmid outputs", 32'({PSEL, PENABLE, HREADYOUT, HRESP}),
          32'b0010);
    check("rstmid hrdata", HRDATA, 32'h0);
    check("rstmid paddr", 32'(PADDR), 32'h0);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    check("rstmid after", 32'({PSEL, PENABLE, HREADYOUT}), 32'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
